// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/fas.sv
// One-bit full adder/subtractor cell: sum is shared, carry-out is carry or borrow by mode.
module fas
   import addsub_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   input  logic i_a_ns,
   output logic o_s,
   output logic o_cout
);

   // Sum and mode-selected carry/borrow.
   always_comb begin
      o_s    = i_a ^ i_b ^ i_cin;
      o_cout = 1'b0;
      unique case (i_a_ns)
         OP_ADD: o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
         OP_SUB: o_cout = (~i_a & i_b) | (~i_a & i_cin) | (i_b & i_cin);
      endcase
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit add/subtract: operands stream LSB-first through one fas cell.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         a_ns,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout
);

   localparam int unsigned CW = $clog2(N + 1);

   state_t         r_state, w_state_d;
   logic [N-1:0]   r_a_sh, w_a_sh_d;
   logic [N-1:0]   r_b_sh, w_b_sh_d;
   logic [N-1:0]   r_r_sh, w_r_sh_d;
   logic           r_cy, w_cy_d;
   logic           r_mode, w_mode_d;
   logic [CW-1:0]  r_cnt, w_cnt_d;

   logic           w_s;
   logic           w_cell_cout;

   fas u_fas (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_cin  (r_cy),
      .i_a_ns (r_mode),
      .o_s    (w_s),
      .o_cout (w_cell_cout)
   );

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_r_sh  <= '0;
         r_cy    <= 1'b0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_a_sh  <= w_a_sh_d;
         r_b_sh  <= w_b_sh_d;
         r_r_sh  <= w_r_sh_d;
         r_cy    <= w_cy_d;
         r_mode  <= w_mode_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Next-state and datapath update; everything holds unless the state says otherwise.
   always_comb begin
      w_state_d = r_state;
      w_a_sh_d  = r_a_sh;
      w_b_sh_d  = r_b_sh;
      w_r_sh_d  = r_r_sh;
      w_cy_d    = r_cy;
      w_mode_d  = r_mode;
      w_cnt_d   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_a_sh_d  = a;
               w_b_sh_d  = b;
               w_mode_d  = a_ns;
               w_cy_d    = 1'b0;
               w_cnt_d   = '0;
               w_state_d = RUN;
            end
         end
         RUN: begin
            // Result fills from the MSB so bit 0 lands at position 0 after N shifts.
            w_r_sh_d = {w_s, r_r_sh[N-1:1]};
            w_cy_d   = w_cell_cout;
            w_a_sh_d = r_a_sh >> 1;
            w_b_sh_d = r_b_sh >> 1;
            w_cnt_d  = r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
               w_state_d = DONE;
            end
         end
         DONE: begin
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      busy   = (r_state == RUN);
      done   = (r_state == DONE);
      result = r_r_sh;
      cout   = r_cy;
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: reference model plus directed vectors.
module tb_serial_addsub;
   import addsub_pkg::*;

   localparam int unsigned N    = 8;
   localparam int unsigned MASK = (1 << N) - 1;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         a_ns  = 1'b0;
   logic [N-1:0] a     = '0;
   logic [N-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   serial_addsub #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a_ns   (a_ns),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
   );

   always #50 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: plain integer add/subtract modulo 2^N.
   function automatic int unsigned ref_res(input int unsigned x, input int unsigned y,
                                           input logic mode);
      if (mode == OP_ADD) return (x + y) & MASK;
      return (x + (1 << N) - y) & MASK;
   endfunction

   function automatic int unsigned ref_cout(input int unsigned x, input int unsigned y,
                                            input logic mode);
      if (mode == OP_ADD) return ((x + y) > MASK) ? 1 : 0;
      return (x < y) ? 1 : 0;
   endfunction

   // Model: m_cyc counts cycles since acceptance (0 idle, 1..N busy, N+1 done).
   int unsigned  m_cyc;
   logic [N-1:0] m_res, m_pend_res;
   logic         m_cout, m_pend_cout;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc       <= 0;
         m_res       <= '0;
         m_cout      <= 1'b0;
         m_pend_res  <= '0;
         m_pend_cout <= 1'b0;
      end else if (m_cyc == 0) begin
         if (start) begin
            m_cyc       <= 1;
            m_pend_res  <= N'(ref_res(a, b, a_ns));
            m_pend_cout <= ref_cout(a, b, a_ns) != 0;
         end
      end else if (m_cyc == N) begin
         m_cyc  <= N + 1;
         m_res  <= m_pend_res;
         m_cout <= m_pend_cout;
      end else if (m_cyc == N + 1) begin
         m_cyc <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
      end
   end

   // Compare DUT against model mid-cycle; result/cout only meaningful outside RUN.
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("busy", busy, (m_cyc >= 1 && m_cyc <= N) ? 1 : 0);
         check("done", done, (m_cyc == N + 1) ? 1 : 0);
         if (m_cyc == 0 || m_cyc == N + 1) begin
            check("result", result, m_res);
            check("cout", cout, m_cout);
         end
      end
   end

   // Run one operation; operands are scrambled during RUN to prove they are latched.
   task automatic do_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic mode, input logic [N-1:0] er, input logic ec);
      int k;
      @(negedge clk);
      a     = ta;
      b     = tb;
      a_ns  = mode;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = ~ta;
      b     = ~tb;
      a_ns  = ~mode;
      k     = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            k = i;
            break;
         end
      end
      check({name, " latency"}, k, N + 1);
      check({name, " result"}, result, er);
      check({name, " cout"}, cout, ec);
   endtask

   initial begin
      int pulses;
      logic [N-1:0] seen_res;

      // Pin the reference model with hand-computed values.
      check("model add wrap", ref_res(8'hFF, 8'h01, OP_ADD), 8'h00);
      check("model sub borrow", ref_res(8'h01, 8'h02, OP_SUB), 8'hFF);
      check("model sub cout", ref_cout(8'h01, 8'h02, OP_SUB), 1);

      repeat (2) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset result", result, 0);
      check("reset cout", cout, 0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      do_op("add 35+4a", 8'h35, 8'h4A, OP_ADD, 8'h7F, 1'b0);
      do_op("add ff+01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1);
      do_op("sub 10-01", 8'h10, 8'h01, OP_SUB, 8'h0F, 1'b0);
      do_op("sub a5-a5", 8'hA5, 8'hA5, OP_SUB, 8'h00, 1'b0);
      do_op("sub 01-02", 8'h01, 8'h02, OP_SUB, 8'hFF, 1'b1);

      // Start pulsed during RUN must be ignored.
      @(negedge clk);
      a = 8'h35; b = 8'h4A; a_ns = OP_ADD; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'h00; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      pulses   = 0;
      seen_res = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            seen_res = result;
         end
      end
      check("busy start pulses", pulses, 1);
      check("busy start result", seen_res, 8'h7F);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      a = 8'h35; b = 8'h4A; a_ns = OP_ADD; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #20;
      rst_n = 1'b0;
      #1;
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst result", result, 0);
      check("midrst cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post-reset 01+01", 8'h01, 8'h01, OP_ADD, 8'h02, 1'b0);

      // Randomized traffic including held start and one async reset.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (i == 300) begin
            #13;
            rst_n = 1'b0;
            #20;
            rst_n = 1'b1;
         end
         a    = N'($urandom);
         b    = N'($urandom);
         a_ns = 1'($urandom);
         if (i >= 400 && i < 450) start = 1'b1;
         else start = ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      repeat (N + 4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial N-bit adder/subtractor built around a single one-bit full adder/subtractor cell. It accepts two N-bit operands and a mode bit through a start/busy/done handshake and streams them LSB-first through the cell, one bit per clock. A carry/borrow flop closes the loop, and a shift register assembles the result. It is the sequential stage that drives the one-bit cell and consumes its sum and carry outputs.

## Interface
- `N`, default 8: operand and result width, minimum 2.
- `CW`, default `$clog2(N+1)`: bit-counter width. This is a localparam, not overridable.
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a new operation. Sampled only in IDLE.
- `a_ns` in 1: mode. 1 = add (A+B), 0 = subtract (A−B). Sampled with `start`.
- `a` in N: operand A, sampled with `start`.
- `b` in N: operand B, sampled with `start`.
- `busy` out 1: high while an operation is in progress (RUN).
- `done` out 1: one-cycle pulse when `result` and `cout` become valid.
- `result` out N: sum or difference, modulo 2^N.
- `cout` out 1: final carry in add mode, final borrow in subtract mode.

## Operation
- **Registers:**
  - `a_sh`, `b_sh`: operand shift registers, shift right.
  - `r_sh`: result shift register, filled from the MSB side.
  - `cy`: carry/borrow flop.
  - `mode`: latched `a_ns`.
  - `cnt`: bit counter, CW bits.
  - `state`.
- **Cell connections:** a = `a_sh[0]`, b = `b_sh[0]`, cin = `cy`, a_ns = `mode`.
- **Cell arithmetic:**
  - s = a⊕b⊕cin in both modes.
  - Add: cout = maj(a,b,cin).
  - Subtract: cout = borrow = (¬a·b) | (¬a·cin) | (b·cin).
- **States:** IDLE, RUN, DONE.
  - **IDLE:** `busy`=0, `done`=0. On `start`=1:
    - load `a_sh`←`a`, `b_sh`←`b`, `mode`←`a_ns`;
    - clear `cy`←0 and `cnt`←0;
    - go to RUN.
  - **RUN:** `busy`=1. Each edge:
    - `r_sh` ← {s, `r_sh[N-1:1]`};
    - `cy` ← cell cout;
    - `a_sh`, `b_sh` shift right by one, zero-fill;
    - `cnt`++.
    - On the edge where `cnt` = N−1, go to DONE.
  - **DONE:** `done`=1 and `busy`=0 for exactly one cycle. `result`=`r_sh`, `cout`=`cy`. Go to IDLE unconditionally.
- **Result hold:** `result` and `cout` keep their values until the next accepted `start`.
- **Mode independence:** the initial carry/borrow is 0 in both modes. Subtraction is therefore true A−B mod 2^N, and `cout`=1 exactly when A<B unsigned.
- **`start` outside IDLE:** ignored in RUN and DONE. No queuing, no effect on the operation in flight.
- **`start` held high:** a new operation is accepted in the IDLE cycle that follows DONE. Back-to-back throughput is one operation per N+2 cycles.
- **Operand/mode changes during RUN:** changes to `a`, `b` or `a_ns` have no effect.

## Timing
- **Reset (`rst_n`=0, any time including mid-RUN):** immediately, without waiting for a clock:
  - state=IDLE;
  - `busy`=0, `done`=0;
  - `result`=0, `cout`=0;
  - `cy`=0, `cnt`=0;
  - all shift registers and `mode` = 0.
  
  The partial operation is discarded. The first `start` after release behaves as from power-up.
- **Latency:** `start` is sampled at edge E0. RUN covers edges E1..EN. DONE is visible in the cycle after EN, and `done` is sampled high at edge EN+1. Total N+1 cycles from acceptance to `done`.
- **Critical path:** `cy`/`a_sh`/`b_sh` → cell (gate-level delays) → `cy`/`r_sh` D inputs. The clock period must exceed the worst-case cell delay. Benches use a period of at least 100 time units.
- **Glitch behaviour:** outputs are registered or decoded from registered state only. `done` and `busy` are glitch-free.

## Structure
- **Shared package `addsub_pkg`:**
  - typedef enum logic [1:0] `{IDLE, RUN, DONE}` as `state_t`;
  - constants `OP_ADD`=1'b1 and `OP_SUB`=1'b0.
- **Sub-module:** one instance of the existing one-bit full adder/subtractor cell `fas`. Its delay parameters are left at default.
- **Remaining logic:** stays in `serial_addsub` (FSM, counter, shift registers, carry flop).

## Test plan
- **Add, no carry:** N=8, add, `a`=0x35, `b`=0x4A → `result`=0x7F, `cout`=0; `done` high exactly 9 cycles after the `start` edge.
- **Add with wrap:** `a`=0xFF, `b`=0x01 → `result`=0x00, `cout`=1.
- **Subtract, no borrow:** `a`=0x10, `b`=0x01 → `result`=0x0F, `cout`=0. Also `a`=`b`=0xA5 → 0x00, `cout`=0.
- **Subtract with borrow:** `a`=0x01, `b`=0x02 → `result`=0xFF, `cout`=1.
- **Busy-time start:** pulse `start` with `a`=0x00, `b`=0x00 during RUN of 0x35+0x4A → ignored; `result`=0x7F, single `done` pulse.
- **Reset mid-operation:** assert `rst_n`=0 at RUN cycle 3 → `busy`, `done`, `result` and `cout` all 0 immediately. After release, 0x01+0x01 → `result`=0x02 after N+1 cycles.
